// File: rtl/phase_pkg.sv
// phase_pkg: phase indices, monitor FSM states and strobe-sample classes
package phase_pkg;
    localparam logic [1:0] PH_FT = 2'd0;
    localparam logic [1:0] PH_DC = 2'd1;
    localparam logic [1:0] PH_EX = 2'd2;
    localparam logic [1:0] PH_WB = 2'd3;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCK} state_t;
    typedef enum logic [1:0] {ZERO, ONE, MULTI} class_t;
endpackage

// File: rtl/phase_classify.sv
// phase_classify: sorts a {FT,DC,EX,WB} strobe vector into ZERO/ONE/MULTI and a phase index
module phase_classify
    import phase_pkg::*;
(
    input  logic [3:0] strobes,
    output class_t     cls,
    output logic [1:0] idx
);
    logic [2:0] ones;
    always_comb begin
        ones = 3'($countones(strobes));
        cls  = ones == 3'd0 ? ZERO : ones == 3'd1 ? ONE : MULTI;
        idx  = strobes[3] ? PH_FT : strobes[2] ? PH_DC : strobes[1] ? PH_EX : PH_WB;
    end
endmodule

// File: rtl/phase_monitor.sv
// phase_monitor: checks FT->DC->EX->WB strobe rotation, reports lock, stage, retire and error counts
// PHASE_MON_STICKY_ERR_EN adds CLR_ERR and ERR_STICKY
module phase_monitor
    import phase_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLK_FT,
    input  logic             CLK_DC,
    input  logic             CLK_EX,
    input  logic             CLK_WB,
    output logic [1:0]       STAGE,
    output logic             LOCKED,
    output logic [CNT_W-1:0] INSTR_CNT,
    output logic             ERR_ONEHOT,
    output logic             ERR_SEQ,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef PHASE_MON_STICKY_ERR_EN
    ,
    input  logic             CLR_ERR,
    output logic             ERR_STICKY
`endif
);
    localparam int RW = $clog2(LOCK_CYCLES + 1);
    state_t        state;
    class_t        cls;
    logic [1:0]    idx;
    logic [RW-1:0] run;
    logic          in_order, e_one, e_seq, err;
    logic [ERR_W-1:0] cnt_inc, cnt_nxt;
    phase_classify u_classify (
        .strobes({CLK_FT, CLK_DC, CLK_EX, CLK_WB}),
        .cls    (cls),
        .idx    (idx)
    );
    always_comb begin
        in_order = idx == STAGE + 2'd1;
        e_one    = state == SEARCH ? cls == MULTI : cls != ONE;
        e_seq    = state != SEARCH && cls == ONE && !in_order;
        err      = e_one | e_seq;
        cnt_inc  = &ERR_CNT ? ERR_CNT : ERR_CNT + 1'b1;
`ifdef PHASE_MON_STICKY_ERR_EN
        cnt_nxt  = err ? (CLR_ERR ? ERR_W'(1) : cnt_inc) : (CLR_ERR ? '0 : ERR_CNT);
`else
        cnt_nxt  = err ? cnt_inc : ERR_CNT;
`endif
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= SEARCH;
            run        <= '0;
            STAGE      <= PH_FT;
            LOCKED     <= 1'b0;
            INSTR_CNT  <= '0;
            ERR_ONEHOT <= 1'b0;
            ERR_SEQ    <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            ERR_ONEHOT <= e_one;
            ERR_SEQ    <= e_seq;
            ERR_CNT    <= cnt_nxt;
            STAGE      <= cls == ONE ? idx : STAGE;
            case (state)
                SEARCH: if (cls == ONE) begin
                    run   <= RW'(1);
                    state <= ACQUIRE;
                end
                ACQUIRE: if (cls != ONE) state <= SEARCH;
                else if (!in_order) run <= RW'(1);
                else begin
                    run <= run + 1'b1;
                    if (run + 1'b1 == RW'(LOCK_CYCLES)) begin
                        state  <= LOCK;
                        LOCKED <= 1'b1;
                    end
                end
                default: if (err) begin
                    state  <= SEARCH;
                    LOCKED <= 1'b0;
                end else if (idx == PH_WB) INSTR_CNT <= INSTR_CNT + 1'b1;
            endcase
        end
    end
`ifdef PHASE_MON_STICKY_ERR_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ERR_STICKY <= 1'b0;
        else ERR_STICKY <= err | (ERR_STICKY & ~CLR_ERR);
    end
`endif
endmodule

// File: tb/tb_phase_monitor.sv
// tb_phase_monitor: directed vectors for phase_monitor (CNT_W=4, ERR_W=2 to reach wrap/saturation quickly)
module tb_phase_monitor;
    localparam logic [3:0] FT = 4'b1000, DC = 4'b0100, EX = 4'b0010, WB = 4'b0001;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] v = 4'b0000;
    logic [1:0] stage;
    logic       locked, err_onehot, err_seq;
    logic [3:0] instr_cnt;
    logic [1:0] err_cnt;
    int         vectors = 0;
    int         miscompares = 0;
`ifdef PHASE_MON_STICKY_ERR_EN
    logic       clr_err = 1'b0;
    logic       err_sticky;
`endif
    always #5 clk = ~clk;
    phase_monitor #(.LOCK_CYCLES(4), .CNT_W(4), .ERR_W(2)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CLK_FT    (v[3]),
        .CLK_DC    (v[2]),
        .CLK_EX    (v[1]),
        .CLK_WB    (v[0]),
        .STAGE     (stage),
        .LOCKED    (locked),
        .INSTR_CNT (instr_cnt),
        .ERR_ONEHOT(err_onehot),
        .ERR_SEQ   (err_seq),
        .ERR_CNT   (err_cnt)
`ifdef PHASE_MON_STICKY_ERR_EN
        ,
        .CLR_ERR   (clr_err),
        .ERR_STICKY(err_sticky)
`endif
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic drive(input logic [3:0] s);
        v = s;
        @(posedge clk);
        #1;
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_stage"}, 32'(stage), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_instr"}, 32'(instr_cnt), 0);
        check({tag, "_eoh"}, 32'(err_onehot), 0);
        check({tag, "_eseq"}, 32'(err_seq), 0);
        check({tag, "_ecnt"}, 32'(err_cnt), 0);
    endtask
    initial begin
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        // idle cycle then first acquisition
        drive(4'b0000); check("idle_eoh", 32'(err_onehot), 0); check("idle_locked", 32'(locked), 0);
        drive(FT); check("acq_ft_stage", 32'(stage), 0); check("acq_ft_locked", 32'(locked), 0);
        drive(DC); check("acq_dc_stage", 32'(stage), 1);
        drive(EX); check("acq_ex_stage", 32'(stage), 2); check("acq_ex_locked", 32'(locked), 0);
        drive(WB); check("lock_locked", 32'(locked), 1); check("lock_stage", 32'(stage), 3);
        check("lock_wb_uncounted", 32'(instr_cnt), 0);
        drive(FT); drive(DC); drive(EX);
        drive(WB); check("first_retire", 32'(instr_cnt), 1);
        check("first_eoh", 32'(err_onehot), 0); check("first_eseq", 32'(err_seq), 0);
        check("first_ecnt", 32'(err_cnt), 0);
        // multi-hot while locked
        drive(FT | EX); check("multi_eoh", 32'(err_onehot), 1); check("multi_locked", 32'(locked), 0);
        check("multi_ecnt", 32'(err_cnt), 1); check("multi_stage", 32'(stage), 3);
        drive(FT); check("multi_pulse_len", 32'(err_onehot), 0);
        drive(DC); drive(EX); check("relock_pending", 32'(locked), 0);
        drive(WB); check("relock", 32'(locked), 1); check("relock_instr", 32'(instr_cnt), 1);
        // out-of-order WB while locked
        drive(FT); drive(DC);
        drive(WB); check("seq_eseq", 32'(err_seq), 1); check("seq_eoh", 32'(err_onehot), 0);
        check("seq_stage", 32'(stage), 3); check("seq_locked", 32'(locked), 0);
        check("seq_instr", 32'(instr_cnt), 1); check("seq_ecnt", 32'(err_cnt), 2);
        drive(DC); check("search_reseed_eseq", 32'(err_seq), 0); check("search_reseed_stage", 32'(stage), 1);
        drive(EX); drive(WB);
        drive(FT); check("relock2", 32'(locked), 1);
        // 15 more retires wrap the 4-bit counter
        for (int i = 0; i < 15; i++) begin
            drive(DC); drive(EX); drive(WB);
            check("wrap_instr", 32'(instr_cnt), 32'((2 + i) % 16));
            drive(FT);
        end
        // error saturation at 3
        drive(4'b0000); check("sat1_eoh", 32'(err_onehot), 1); check("sat1_ecnt", 32'(err_cnt), 3);
        check("sat1_locked", 32'(locked), 0);
        drive(4'b1111); check("sat2_eoh", 32'(err_onehot), 1); check("sat2_ecnt", 32'(err_cnt), 3);
        drive(4'b1100); check("sat3_eoh", 32'(err_onehot), 1);
        drive(4'b0000); check("search_zero_ignored", 32'(err_onehot), 0);
        drive(FT); check("sat_acq_eoh", 32'(err_onehot), 0);
        drive(EX); check("sat4_eseq", 32'(err_seq), 1); check("sat4_stage", 32'(stage), 2);
        drive(4'b0000); check("sat5_eoh", 32'(err_onehot), 1); check("sat5_eseq", 32'(err_seq), 0);
        check("sat5_ecnt", 32'(err_cnt), 3); check("sat_instr_hold", 32'(instr_cnt), 0);
        // asynchronous reset between edges
        drive(FT); drive(DC); drive(EX); drive(WB); drive(FT); drive(DC); drive(EX);
        drive(WB); check("pre_rst_locked", 32'(locked), 1); check("pre_rst_instr", 32'(instr_cnt), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk); #2 rst_n = 1'b1;
        drive(DC); check("post_rst_stage", 32'(stage), 1); check("post_rst_eoh", 32'(err_onehot), 0);
        check("post_rst_eseq", 32'(err_seq), 0);
`ifdef PHASE_MON_STICKY_ERR_EN
        check("sticky_init", 32'(err_sticky), 0);
        drive(4'b0000); check("sticky_set", 32'(err_sticky), 1); check("sticky_ecnt1", 32'(err_cnt), 1);
        for (int i = 0; i < 100; i++) drive(4'b0000);
        check("sticky_hold", 32'(err_sticky), 1);
        drive(4'b1111); check("sticky_ecnt2", 32'(err_cnt), 2);
        clr_err = 1'b1;
        drive(4'b0011); check("clr_err_wins_sticky", 32'(err_sticky), 1);
        check("clr_err_wins_ecnt", 32'(err_cnt), 1);
        drive(4'b0000); check("clr_sticky", 32'(err_sticky), 0); check("clr_ecnt", 32'(err_cnt), 0);
        clr_err = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
